// File: rtl/fpu_pipe_arbiter.sv
// fpu_pipe_arbiter: round-robin issue arbiter and valid/tag sequencer for the shared add/mul FP pipeline
module fpu_pipe_arbiter #(
  parameter int PipeDepth  = 4,
  parameter int CountWidth = 3
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic                  AddReqValid,
  output logic                  AddReqReady,
  input  logic                  MulReqValid,
  output logic                  MulReqReady,
  input  logic                  Flush,
  output logic                  IssueValid,
  output logic                  IssueMULorADD,
  output logic                  PipeEn,
  output logic                  MULorADD,
  output logic                  AddResValid,
  input  logic                  AddResReady,
  output logic                  MulResValid,
  input  logic                  MulResReady,
  output logic [CountWidth-1:0] InFlight
);
  logic [PipeDepth-1:0] stage_valid_q, stage_valid_d;
  logic [PipeDepth-1:0] stage_tag_q, stage_tag_d;
  logic                 last_grant_q, last_grant_d;
  logic                 head_valid, head_tag, head_accept;
  logic                 grant_add, grant_mul;
  logic [CountWidth-1:0] in_flight;
  // head status, global stall, round-robin grant and result steering
  always_comb begin
    head_valid    = stage_valid_q[PipeDepth-1];
    head_tag      = stage_tag_q[PipeDepth-1];
    head_accept   = head_valid & (head_tag ? MulResReady : AddResReady);
    PipeEn        = ~Flush & (~head_valid | head_accept);
    grant_add     = AddReqValid & (~MulReqValid | last_grant_q);
    grant_mul     = MulReqValid & (~AddReqValid | ~last_grant_q);
    AddReqReady   = PipeEn & grant_add;
    MulReqReady   = PipeEn & grant_mul;
    IssueValid    = AddReqReady | MulReqReady;
    IssueMULorADD = MulReqReady;
    MULorADD      = head_tag;
    AddResValid   = ~Flush & head_valid & ~head_tag;
    MulResValid   = ~Flush & head_valid & head_tag;
  end
  // next state: shift on advance, clear valids on flush, otherwise hold
  always_comb begin
    stage_valid_d = Flush ? '0 : PipeEn ? {stage_valid_q[PipeDepth-2:0], IssueValid} : stage_valid_q;
    stage_tag_d   = PipeEn ? {stage_tag_q[PipeDepth-2:0], IssueMULorADD} : stage_tag_q;
    last_grant_d  = (PipeEn & IssueValid) ? IssueMULorADD : last_grant_q;
  end
  // occupancy count over every stage including the head
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < PipeDepth; i++) in_flight = in_flight + CountWidth'(stage_valid_q[i]);
    InFlight = in_flight;
  end
  // state registers; last grant resets to MUL so ADD wins the first contention
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      stage_valid_q <= '0;
      stage_tag_q   <= '0;
      last_grant_q  <= 1'b1;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_tag_q   <= stage_tag_d;
      last_grant_q  <= last_grant_d;
    end
  end
endmodule

// File: tb/tb_fpu_pipe_arbiter.sv
// tb_fpu_pipe_arbiter: directed self-checking bench for fpu_pipe_arbiter
module tb_fpu_pipe_arbiter;
  logic       Clk = 1'b0;
  logic       ResetN, AddReqValid, MulReqValid, Flush, AddResReady, MulResReady;
  logic       AddReqReady, MulReqReady, IssueValid, IssueMULorADD, PipeEn, MULorADD;
  logic       AddResValid, MulResValid;
  logic [2:0] InFlight;
  int         checks = 0;
  int         errors = 0;
  fpu_pipe_arbiter #(.PipeDepth(4), .CountWidth(3)) dut (
    .Clk(Clk), .ResetN(ResetN),
    .AddReqValid(AddReqValid), .AddReqReady(AddReqReady),
    .MulReqValid(MulReqValid), .MulReqReady(MulReqReady),
    .Flush(Flush), .IssueValid(IssueValid), .IssueMULorADD(IssueMULorADD),
    .PipeEn(PipeEn), .MULorADD(MULorADD),
    .AddResValid(AddResValid), .AddResReady(AddResReady),
    .MulResValid(MulResValid), .MulResReady(MulResReady),
    .InFlight(InFlight)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask
  task automatic req(input logic a, input logic m);
    AddReqValid = a;
    MulReqValid = m;
  endtask
  initial begin
    ResetN = 1'b0; Flush = 1'b0; AddResReady = 1'b1; MulResReady = 1'b1;
    req(0, 0);
    #2;
    chk("rst_pipeen", PipeEn, 1);
    chk("rst_issue", IssueValid, 0);
    chk("rst_tag", MULorADD, 0);
    chk("rst_inflight", InFlight, 0);
    chk("rst_resv", {AddResValid, MulResValid}, 0);
    cyc();
    ResetN = 1'b1;
    // contention: grants alternate ADD, MUL, ADD, MUL; results follow in order
    for (int c = 0; c < 9; c++) begin
      req(c < 4, c < 4);
      #2;
      chk("cont_inflight", InFlight, (c <= 4) ? c : 8 - c);
      if (c < 4) begin
        chk("cont_mulgrant", MulReqReady, c % 2);
        chk("cont_addgrant", AddReqReady, 1 - c % 2);
        chk("cont_issuetag", IssueMULorADD, c % 2);
      end
      if (c >= 4 && c < 8) begin
        chk("cont_tag", MULorADD, (c - 4) % 2);
        chk("cont_addres", AddResValid, 1 - (c - 4) % 2);
        chk("cont_mulres", MulResValid, (c - 4) % 2);
      end
      cyc();
    end
    // single ADD: result four cycles after acceptance
    req(1, 0);
    #2;
    chk("add_ready", AddReqReady, 1);
    chk("add_issue", {IssueValid, IssueMULorADD}, 2'b10);
    cyc();
    req(0, 0);
    for (int k = 1; k <= 5; k++) begin
      #2;
      chk("add_inflight", InFlight, (k <= 4) ? 1 : 0);
      chk("add_resv", AddResValid, k == 4);
      chk("add_mulresv", MulResValid, 0);
      if (k == 4) chk("add_tag", MULorADD, 0);
      cyc();
    end
    // backpressure: four MULs fill the pipe with the MUL consumer not ready
    MulResReady = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req(0, 1);
      #2;
      chk("bp_fill_ready", MulReqReady, 1);
      cyc();
    end
    for (int c = 0; c < 2; c++) begin
      req(1, 1);
      #2;
      chk("bp_pipeen", PipeEn, 0);
      chk("bp_readies", {AddReqReady, MulReqReady}, 0);
      chk("bp_inflight", InFlight, 4);
      chk("bp_mulres", MulResValid, 1);
      cyc();
    end
    MulResReady = 1'b1;
    #2;
    chk("bp_accept_pipeen", PipeEn, 1);
    chk("bp_accept_add", AddReqReady, 1);
    chk("bp_accept_mul", MulReqReady, 0);
    cyc();
    MulResReady = 1'b0;
    req(0, 0);
    #2;
    chk("bp_one_pipeen", PipeEn, 0);
    chk("bp_one_inflight", InFlight, 4);
    chk("bp_one_head", MulResValid, 1);
    MulResReady = 1'b1;
    for (int c = 0; c < 5; c++) cyc();
    chk("bp_drain", InFlight, 0);
    // flush with three in flight; the request seen during flush waits a cycle
    req(1, 0); cyc();
    req(0, 1); cyc();
    req(1, 0); cyc();
    req(0, 1);
    Flush = 1'b1;
    #2;
    chk("fl_inflight_pre", InFlight, 3);
    chk("fl_ready", MulReqReady, 0);
    chk("fl_pipeen", PipeEn, 0);
    chk("fl_issue", IssueValid, 0);
    cyc();
    Flush = 1'b0;
    #2;
    chk("fl_inflight_post", InFlight, 0);
    chk("fl_retry_ready", MulReqReady, 1);
    cyc();
    req(0, 0);
    for (int k = 1; k <= 4; k++) begin
      #2;
      chk("fl_addres", AddResValid, 0);
      chk("fl_mulres", MulResValid, k == 4);
      cyc();
    end
    // flush while the head result is ready: it is discarded
    req(1, 0); cyc();
    req(0, 0);
    for (int c = 0; c < 3; c++) cyc();
    Flush = 1'b1;
    #2;
    chk("flh_addres", AddResValid, 0);
    cyc();
    Flush = 1'b0;
    #2;
    chk("flh_inflight", InFlight, 0);
    // async reset with two ops in flight; last grant was ADD before reset
    req(0, 1); cyc();
    req(1, 0); cyc();
    req(0, 0);
    #2;
    chk("ar_inflight_pre", InFlight, 2);
    ResetN = 1'b0;
    #1;
    chk("ar_inflight", InFlight, 0);
    chk("ar_pipeen", PipeEn, 1);
    chk("ar_issue", IssueValid, 0);
    #1;
    ResetN = 1'b1;
    cyc();
    req(1, 1);
    #2;
    chk("ar_first_add", AddReqReady, 1);
    chk("ar_first_mul", MulReqReady, 0);
    cyc();
    req(0, 0);
    for (int k = 1; k <= 4; k++) begin
      #2;
      chk("ar_mulres", MulResValid, 0);
      chk("ar_addres", AddResValid, k == 4);
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
